// File: rtl/rr_arb8.sv
// Eight-client arbiter: round-robin or fixed-highest priority, registered one-hot grant,
// with optional hold-time preemption of an owner that keeps its request up too long.
//
// state  | meaning
// S_IDLE | no owner, grant outputs are zero
// S_OWN  | gnt_idx owns the resource, hold counter running
module rr_arb8 #(
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       preempt
);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_gnt;
  logic [2:0] r_idx;
  logic       r_vld;
  logic       r_preempt;
  logic [7:0] r_hold;
  logic [2:0] r_last;

  logic [7:0] w_cand;
  logic [2:0] w_win;
  logic       w_owner_req;
  logic       w_grant;
  logic [2:0] w_idx_nxt;
  logic       w_vld_nxt;
  logic       w_pre_nxt;
  logic [7:0] w_hold_nxt;
  logic [2:0] w_last_nxt;

  // Round-robin searches last+1, last+2, ... (wrapping); fixed mode keeps the highest index.
  function automatic logic [2:0] pick(input logic [7:0] c, input logic [2:0] last);
    logic [2:0] w;
    logic [2:0] j;
    logic       found;
    w     = '0;
    j     = '0;
    found = 1'b0;
    if (RR_MODE != 0) begin
      for (int k = 1; k <= 8; k++) begin
        j = last + 3'(k);
        if (!found && c[j]) begin
          w     = j;
          found = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (c[k]) w = 3'(k);
      end
    end
    return w;
  endfunction

  always_comb begin
    w_cand      = (r_state == S_OWN) ? (req & ~r_gnt) : req;
    w_win       = pick(w_cand, r_last);
    w_owner_req = |(req & r_gnt);
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_idx_nxt   = r_idx;
    w_vld_nxt   = r_vld;
    w_pre_nxt   = 1'b0;
    w_hold_nxt  = r_hold;
    w_last_nxt  = r_last;

    case (r_state)
      S_IDLE: begin
        if (|req) w_grant = 1'b1;
      end
      S_OWN: begin
        if (!w_owner_req) begin
          if (|w_cand) begin
            w_grant = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
            w_vld_nxt   = 1'b0;
            w_hold_nxt  = '0;
          end
        end else if ((MAX_HOLD != 0) && (r_hold == HOLD_LAST)) begin
          // A lone owner keeps the grant; the counter just restarts its window.
          w_hold_nxt = '0;
          if (|w_cand) begin
            w_grant   = 1'b1;
            w_pre_nxt = 1'b1;
          end
        end else if (r_hold != 8'hFF) begin
          w_hold_nxt = r_hold + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
        w_vld_nxt   = 1'b0;
        w_hold_nxt  = '0;
      end
    endcase

    if (w_grant) begin
      w_state_nxt = S_OWN;
      w_idx_nxt   = w_win;
      w_vld_nxt   = 1'b1;
      w_hold_nxt  = '0;
      w_last_nxt  = w_win;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_idx     <= '0;
      r_vld     <= 1'b0;
      r_preempt <= 1'b0;
      r_hold    <= '0;
      r_last    <= 3'd7;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_vld_nxt ? (8'd1 << w_idx_nxt) : 8'd0;
      r_idx     <= w_idx_nxt;
      r_vld     <= w_vld_nxt;
      r_preempt <= w_pre_nxt;
      r_hold    <= w_hold_nxt;
      r_last    <= w_last_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_idx;
  assign gnt_vld = r_vld;
  assign preempt = r_preempt;

endmodule

// File: tb/tb_rr_arb8.sv
// Bench for rr_arb8: three parameterisations share one request bus and are compared
// against an owner/queue-level model, plus directed scenario checks.
module tb_rr_arb8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;

  logic [7:0] gnt_o   [3];
  logic [2:0] idx_o   [3];
  logic       vld_o   [3];
  logic       pre_o   [3];

  int checks;
  int failures;

  // 0: defaults (RR, hold 8); 1: RR hold 4; 2: fixed priority, no preemption
  localparam int P_RR [3] = '{1, 1, 0};
  localparam int P_MH [3] = '{8, 4, 0};

  rr_arb8 #(.RR_MODE(1), .MAX_HOLD(8)) dut_def (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt_o[0]), .gnt_idx(idx_o[0]), .gnt_vld(vld_o[0]), .preempt(pre_o[0]));
  rr_arb8 #(.RR_MODE(1), .MAX_HOLD(4)) dut_rr4 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt_o[1]), .gnt_idx(idx_o[1]), .gnt_vld(vld_o[1]), .preempt(pre_o[1]));
  rr_arb8 #(.RR_MODE(0), .MAX_HOLD(0)) dut_fix (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt_o[2]), .gnt_idx(idx_o[2]), .gnt_vld(vld_o[2]), .preempt(pre_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner is -1 when nobody holds the resource.
  int m_owner [3] = '{-1, -1, -1};
  int m_hold  [3] = '{0, 0, 0};
  int m_last  [3] = '{7, 7, 7};
  bit m_pre   [3] = '{0, 0, 0};

  function automatic int pick(input logic [7:0] c, input int rr, input int last);
    if (rr != 0) begin
      for (int k = 1; k <= 8; k++) if (c[(last + k) % 8]) return (last + k) % 8;
    end else begin
      for (int j = 7; j >= 0; j--) if (c[j]) return j;
    end
    return -1;
  endfunction

  function automatic void model_step(input int i);
    logic [7:0] others;
    int w;
    if (!rst_n) begin
      m_owner[i] = -1; m_hold[i] = 0; m_last[i] = 7; m_pre[i] = 0;
      return;
    end
    m_pre[i] = 0;
    if (m_owner[i] < 0) begin
      if (req != 0) begin
        w = pick(req, P_RR[i], m_last[i]);
        m_owner[i] = w; m_last[i] = w; m_hold[i] = 0;
      end
      return;
    end
    others = req;
    others[m_owner[i]] = 1'b0;
    if (!req[m_owner[i]]) begin
      m_hold[i] = 0;
      if (others != 0) begin
        w = pick(others, P_RR[i], m_last[i]);
        m_owner[i] = w; m_last[i] = w;
      end else begin
        m_owner[i] = -1;
      end
    end else if (P_MH[i] != 0 && m_hold[i] == P_MH[i] - 1) begin
      m_hold[i] = 0;
      if (others != 0) begin
        w = pick(others, P_RR[i], m_last[i]);
        m_owner[i] = w; m_last[i] = w; m_pre[i] = 1;
      end
    end else if (m_hold[i] < 255) begin
      m_hold[i] = m_hold[i] + 1;
    end
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) model_step(i);
  end

  function automatic logic [12:0] exp_vec(input int i);
    logic [7:0] g;
    logic [2:0] x;
    g = (m_owner[i] >= 0) ? 8'(1 << m_owner[i]) : 8'd0;
    x = (m_owner[i] >= 0) ? 3'(m_owner[i]) : 3'd0;
    return {g, x, (m_owner[i] >= 0), m_pre[i]};
  endfunction

  function automatic logic [12:0] act_vec(input int i);
    return {gnt_o[i], idx_o[i], vld_o[i], pre_o[i]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_vec(i) !== 13'h0) begin
          failures++;
          $display("FAIL reset_outputs dut%0d cyc%0d got=%h want=0", i, c, act_vec(i));
        end
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_o[0] !== 8'h01 || idx_o[0] !== 3'd0 || vld_o[0] !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_rr got gnt=%h idx=%0d vld=%b want gnt=01 idx=0 vld=1",
               gnt_o[0], idx_o[0], vld_o[0]);
    end
    checks++;
    if (gnt_o[2] !== 8'h80) begin
      failures++;
      $display("FAIL reset_first_fixed got gnt=%h want 80", gnt_o[2]);
    end
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    req = 8'h20;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (gnt_o[i] !== 8'h20 || idx_o[i] !== 3'd5 || vld_o[i] !== 1'b1 || pre_o[i] !== 1'b0) begin
          failures++;
          $display("FAIL single_hold dut%0d cyc%0d got gnt=%h idx=%0d pre=%b want gnt=20 idx=5 pre=0",
                   i, c, gnt_o[i], idx_o[i], pre_o[i]);
        end
      end
    end
    req = 8'h00;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (gnt_o[i] !== 8'h00 || vld_o[i] !== 1'b0 || idx_o[i] !== 3'd0) begin
        failures++;
        $display("FAIL single_drop dut%0d got gnt=%h vld=%b want gnt=00 vld=0", i, gnt_o[i], vld_o[i]);
      end
    end
  endtask

  task automatic test_rotation();
    logic [7:0] want_g;
    logic       want_p;
    do_reset();
    @(negedge clk);
    req = 8'hFF;
    for (int t = 0; t < 36; t++) begin
      @(negedge clk);
      want_g = 8'h01 << ((t / 4) % 8);
      want_p = (t > 0) && (t % 4 == 0);
      checks++;
      if (gnt_o[1] !== want_g || pre_o[1] !== want_p) begin
        failures++;
        $display("FAIL rotation t=%0d got gnt=%h pre=%b want gnt=%h pre=%b",
                 t, gnt_o[1], pre_o[1], want_g, want_p);
      end
    end
  endtask

  task automatic test_fixed();
    logic [7:0] want [7];
    logic [7:0] seq_req [7];
    want    = '{8'h10, 8'h10, 8'h02, 8'h02, 8'h01, 8'h01, 8'h00};
    seq_req = '{8'h13, 8'h03, 8'h03, 8'h01, 8'h01, 8'h00, 8'h00};
    do_reset();
    @(negedge clk);
    req = 8'h13;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks++;
      if (gnt_o[2] !== want[c] || pre_o[2] !== 1'b0) begin
        failures++;
        $display("FAIL fixed_order step%0d got gnt=%h pre=%b want gnt=%h pre=0",
                 c, gnt_o[2], pre_o[2], want[c]);
      end
      req = seq_req[c];
    end
  endtask

  task automatic test_hog();
    bit seen;
    do_reset();
    @(negedge clk);
    req = 8'h08;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (gnt_o[1] !== 8'h08 || pre_o[1] !== 1'b0) begin
        failures++;
        $display("FAIL hog_hold cyc%0d got gnt=%h pre=%b want gnt=08 pre=0", c, gnt_o[1], pre_o[1]);
      end
    end
    req  = 8'h48;
    seen = 0;
    for (int c = 0; c < 4 && !seen; c++) begin
      @(negedge clk);
      if (gnt_o[1] !== 8'h08) begin
        seen = 1;
        checks++;
        if (gnt_o[1] !== 8'h40 || pre_o[1] !== 1'b1) begin
          failures++;
          $display("FAIL hog_preempt got gnt=%h pre=%b want gnt=40 pre=1", gnt_o[1], pre_o[1]);
        end
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL hog_timeout got gnt=%h after 4 cycles want 40", gnt_o[1]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    req = 8'h04;
    @(negedge clk);
    checks++;
    if (gnt_o[0] !== 8'h04) begin
      failures++;
      $display("FAIL b2b_first got gnt=%h want 04", gnt_o[0]);
    end
    req = 8'h08;
    @(negedge clk);
    checks++;
    if (gnt_o[0] !== 8'h08 || vld_o[0] !== 1'b1 || pre_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_handover got gnt=%h vld=%b pre=%b want gnt=08 vld=1 pre=0",
               gnt_o[0], vld_o[0], pre_o[0]);
    end
    rst_n = 1'b0;
    req   = 8'hFF;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (act_vec(i) !== 13'h0) begin
        failures++;
        $display("FAIL midrun_reset dut%0d got=%h want=0", i, act_vec(i));
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_o[0] !== 8'h01) begin
      failures++;
      $display("FAIL reset_restart got gnt=%h want 01", gnt_o[0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (act_vec(i) !== exp_vec(i)) begin
          failures++;
          $display("FAIL random_model dut%0d cyc%0d got={gnt,idx,vld,pre}=%h want=%h",
                   i, c, act_vec(i), exp_vec(i));
        end
        checks++;
        if (!$onehot0(gnt_o[i]) || (vld_o[i] !== |gnt_o[i]) ||
            (vld_o[i] ? (gnt_o[i] !== (8'd1 << idx_o[i])) : (idx_o[i] !== 3'd0)) ||
            (pre_o[i] && !vld_o[i])) begin
          failures++;
          $display("FAIL random_invariant dut%0d cyc%0d got gnt=%h idx=%0d vld=%b pre=%b",
                   i, c, gnt_o[i], idx_o[i], vld_o[i], pre_o[i]);
        end
      end
      if ($urandom_range(0, 9) == 0) req = 8'($urandom);
      else req = req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      rst_n = ($urandom_range(0, 99) != 0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    req      = 8'h00;
    test_reset();
    test_single();
    test_rotation();
    test_fixed();
    test_hog();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
